// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg: shared writeback-source encoding and load funct3 codes for the MEM/WB stage.
package rv_wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/halfword out of a raw memory word and sign/zero extends it.
module load_extend
    import rv_wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] raw,
    input  logic [1:0]       offset,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data,
    output logic             illegal
);

    // Widen to at least 32 bits so every byte lane index stays in range for narrow builds
    localparam int WW = WIDTH < 32 ? 32 : WIDTH;

    logic [WW-1:0]    wide;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] zb;
    logic [WIDTH-1:0] zh;

    always_comb begin
        wide    = WW'(raw);
        b       = wide[{offset, 3'b000} +: 8];
        h       = wide[{offset[1], 4'b0000} +: 16];
        sb      = WIDTH'($signed(b));
        sh      = WIDTH'($signed(h));
        zb      = WIDTH'(b);
        zh      = WIDTH'(h);
        illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        data    = funct3 == F3_LB  ? sb :
                  funct3 == F3_LBU ? zb :
                  funct3 == F3_LH  ? sh :
                  funct3 == F3_LHU ? zh : raw;
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB stage register, load extension, writeback mux and retire counter;
// drives the register bank write port, which samples it on the following falling edge.
module mem_wb_writeback
    import rv_wb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_VALID,
    input  logic             MEM_REGWRITE,
    input  logic [1:0]       MEM_WB_SEL,
    input  logic [2:0]       MEM_FUNCT3,
    input  logic [AW-1:0]    MEM_ADR_WR_REG,
    input  logic [WIDTH-1:0] MEM_ALU_RESULT,
    input  logic [WIDTH-1:0] MEM_RD_DATA,
    input  logic [WIDTH-1:0] MEM_PC_PLUS4,
    input  logic [WIDTH-1:0] MEM_IMM,
    input  logic             STALL,
    input  logic             FLUSH,
    output logic             REGWRITE,
    output logic [AW-1:0]    ADR_WR_REG,
    output logic [WIDTH-1:0] WR_DATA,
    output logic             WB_VALID,
    output logic             LOAD_ERR,
    output logic [WIDTH-1:0] RETIRE_COUNT
);

    logic             valid_q, valid_d;
    logic             regwrite_q, regwrite_d;
    wb_sel_t          wb_sel_q, wb_sel_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] pc4_q, pc4_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] load_data;
    logic             load_illegal;

    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .raw     (rdata_q),
        .offset  (alu_q[1:0]),
        .funct3  (funct3_q),
        .data    (load_data),
        .illegal (load_illegal)
    );

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        wb_sel_d   = wb_sel_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        pc4_d      = pc4_q;
        imm_d      = imm_q;
        if (FLUSH) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            wb_sel_d   = WB_ALU;
            funct3_d   = '0;
            rd_d       = '0;
            alu_d      = '0;
            rdata_d    = '0;
            pc4_d      = '0;
            imm_d      = '0;
        end else if (!STALL) begin
            valid_d    = MEM_VALID;
            regwrite_d = MEM_REGWRITE;
            wb_sel_d   = wb_sel_t'(MEM_WB_SEL);
            funct3_d   = MEM_FUNCT3;
            rd_d       = MEM_ADR_WR_REG;
            alu_d      = MEM_ALU_RESULT;
            rdata_d    = MEM_RD_DATA;
            pc4_d      = MEM_PC_PLUS4;
            imm_d      = MEM_IMM;
        end
        // An instruction retires when it leaves the stage, and a flush also makes it leave
        cnt_d = cnt_q + WIDTH'(valid_q && (FLUSH || !STALL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            wb_sel_q   <= WB_ALU;
            funct3_q   <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            wb_sel_q   <= wb_sel_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            pc4_q      <= pc4_d;
            imm_q      <= imm_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        LOAD_ERR     = valid_q && wb_sel_q == WB_LOAD && load_illegal;
        REGWRITE     = valid_q && regwrite_q && rd_q != '0 && !LOAD_ERR;
        ADR_WR_REG   = rd_q;
        WB_VALID     = valid_q;
        RETIRE_COUNT = cnt_q;
        WR_DATA      = !valid_q              ? '0        :
                       wb_sel_q == WB_LOAD   ? load_data :
                       wb_sel_q == WB_PC4    ? pc4_q     :
                       wb_sel_q == WB_IMM    ? imm_q     : alu_q;
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: table-driven vectors plus directed stall/flush/reset/wrap sequences.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0, regwrite = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [2:0]  f3 = 3'b000;
    logic [4:0]  rd = 5'd0;
    logic [31:0] alu = 32'd0, rdat = 32'd0, pc4 = 32'd0, imm = 32'd0;

    logic        o_rw, o_vld, o_err;
    logic [4:0]  o_adr;
    logic [31:0] o_data, o_cnt;
    logic        n_rw, n_vld, n_err;
    logic [4:0]  n_adr;
    logic [7:0]  n_data, n_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 0;
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    mem_wb_writeback #(.WIDTH(32), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .MEM_VALID(valid), .MEM_REGWRITE(regwrite), .MEM_WB_SEL(sel),
        .MEM_FUNCT3(f3), .MEM_ADR_WR_REG(rd), .MEM_ALU_RESULT(alu), .MEM_RD_DATA(rdat),
        .MEM_PC_PLUS4(pc4), .MEM_IMM(imm), .STALL(stall), .FLUSH(flush),
        .REGWRITE(o_rw), .ADR_WR_REG(o_adr), .WR_DATA(o_data), .WB_VALID(o_vld),
        .LOAD_ERR(o_err), .RETIRE_COUNT(o_cnt)
    );

    mem_wb_writeback #(.WIDTH(8), .DEPTH(32)) dut8 (
        .clk(clk), .rst(rst), .MEM_VALID(valid), .MEM_REGWRITE(regwrite), .MEM_WB_SEL(sel),
        .MEM_FUNCT3(f3), .MEM_ADR_WR_REG(rd), .MEM_ALU_RESULT(alu[7:0]), .MEM_RD_DATA(rdat[7:0]),
        .MEM_PC_PLUS4(pc4[7:0]), .MEM_IMM(imm[7:0]), .STALL(stall), .FLUSH(flush),
        .REGWRITE(n_rw), .ADR_WR_REG(n_adr), .WR_DATA(n_data), .WB_VALID(n_vld),
        .LOAD_ERR(n_err), .RETIRE_COUNT(n_cnt)
    );

    typedef struct {
        logic        v, rw;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu, rdat, pc4, imm;
        logic        e_rw, e_err, e_vld;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic e_rw, input logic [4:0] e_adr,
                           input logic [31:0] e_data, input logic e_err, input logic e_vld);
        chk({name, ".regwrite"}, 32'(o_rw), 32'(e_rw));
        chk({name, ".adr"}, 32'(o_adr), 32'(e_adr));
        chk({name, ".wr_data"}, o_data, e_data);
        chk({name, ".load_err"}, 32'(o_err), 32'(e_err));
        chk({name, ".wb_valid"}, 32'(o_vld), 32'(e_vld));
        chk({name, ".retire"}, o_cnt, exp_cnt);
        chk({name, ".retire8"}, 32'(n_cnt), 32'(exp_cnt[7:0]));
    endtask

    task automatic drive(input vec_t t);
        valid = t.v; regwrite = t.rw; sel = t.sel; f3 = t.f3; rd = t.rd;
        alu = t.alu; rdat = t.rdat; pc4 = t.pc4; imm = t.imm;
    endtask

    task automatic tick();
        if (prev_valid && (flush || !stall)) exp_cnt++;
        prev_valid = flush ? 1'b0 : stall ? prev_valid : valid;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] RD = 32'h8070_60F0;

    initial begin
        tbl[0]  = '{1, 1, 2'b00, 3'b000, 5'd5,  32'h0000_1234, RD, 0, 0, 1, 0, 1, 32'h0000_1234};
        tbl[1]  = '{1, 1, 2'b00, 3'b000, 5'd0,  32'h0000_1234, RD, 0, 0, 0, 0, 1, 32'h0000_1234};
        tbl[2]  = '{1, 1, 2'b01, 3'b000, 5'd3,  32'h0000_1003, RD, 0, 0, 1, 0, 1, 32'hFFFF_FF80};
        tbl[3]  = '{1, 1, 2'b01, 3'b100, 5'd4,  32'h0000_1000, RD, 0, 0, 1, 0, 1, 32'h0000_00F0};
        tbl[4]  = '{1, 1, 2'b01, 3'b001, 5'd6,  32'h0000_1002, RD, 0, 0, 1, 0, 1, 32'hFFFF_8070};
        tbl[5]  = '{1, 1, 2'b01, 3'b101, 5'd7,  32'h0000_1002, RD, 0, 0, 1, 0, 1, 32'h0000_8070};
        tbl[6]  = '{1, 1, 2'b01, 3'b010, 5'd8,  32'h0000_1001, RD, 0, 0, 1, 0, 1, 32'h8070_60F0};
        tbl[7]  = '{1, 1, 2'b01, 3'b011, 5'd9,  32'h0000_1000, RD, 0, 0, 0, 1, 1, 32'h8070_60F0};
        tbl[8]  = '{1, 1, 2'b11, 3'b000, 5'd10, 32'h0000_0000, RD, 0, 32'hABCD_E000, 1, 0, 1, 32'hABCD_E000};
        tbl[9]  = '{1, 1, 2'b10, 3'b000, 5'd11, 32'h0000_0000, RD, 32'h44, 0, 1, 0, 1, 32'h0000_0044};
        tbl[10] = '{0, 1, 2'b00, 3'b000, 5'd12, 32'h0000_0055, RD, 0, 0, 0, 0, 0, 32'h0000_0000};
        tbl[11] = '{1, 0, 2'b00, 3'b000, 5'd13, 32'h0000_0077, RD, 0, 0, 0, 0, 1, 32'h0000_0077};
        tbl[12] = '{1, 1, 2'b01, 3'b000, 5'd14, 32'h0000_1001, RD, 0, 0, 1, 0, 1, 32'h0000_0060};
        tbl[13] = '{1, 1, 2'b01, 3'b000, 5'd15, 32'h0000_1002, RD, 0, 0, 1, 0, 1, 32'h0000_0070};
        tbl[14] = '{1, 1, 2'b01, 3'b001, 5'd16, 32'h0000_1003, RD, 0, 0, 1, 0, 1, 32'hFFFF_8070};
        tbl[15] = '{1, 1, 2'b01, 3'b001, 5'd17, 32'h0000_1001, RD, 0, 0, 1, 0, 1, 32'h0000_60F0};
        tbl[16] = '{1, 1, 2'b00, 3'b110, 5'd18, 32'h0000_0099, RD, 0, 0, 1, 0, 1, 32'h0000_0099};
        tbl[17] = '{0, 1, 2'b01, 3'b111, 5'd19, 32'h0000_1000, RD, 0, 0, 0, 0, 0, 32'h0000_0000};

        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk_all("idle", 0, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i]);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_rw, tbl[i].rd, tbl[i].e_data,
                    tbl[i].e_err, tbl[i].e_vld);
        end

        drive('{1, 1, 2'b10, 3'b000, 5'd1, 32'h0, RD, 32'h100, 0, 0, 0, 0, 0});
        tick();
        chk_all("pc4_load", 1, 5'd1, 32'h100, 0, 1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive('{1, 1, 2'b00, 3'b000, 5'(20 + i), 32'hDEAD_0000 + i, RD, 32'h200, 0, 0, 0, 0, 0});
            tick();
            chk_all($sformatf("stall%0d", i), 1, 5'd1, 32'h100, 0, 1);
        end
        stall = 1'b0;
        drive('{1, 1, 2'b00, 3'b000, 5'd2, 32'h0000_0ABC, RD, 0, 0, 0, 0, 0, 0});
        tick();
        chk_all("stall_release", 1, 5'd2, 32'h0ABC, 0, 1);

        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk_all("flush_stall", 0, 0, 0, 0, 0);
        stall = 1'b0;
        flush = 1'b0;
        drive('{0, 0, 2'b00, 3'b000, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0});
        tick();
        chk_all("post_flush", 0, 0, 0, 0, 0);

        drive('{1, 1, 2'b00, 3'b000, 5'd5, 32'h0000_1234, RD, 0, 0, 0, 0, 0, 0});
        tick();
        chk_all("pre_reset", 1, 5'd5, 32'h1234, 0, 1);
        #2 rst = 1'b0;
        #1;
        exp_cnt = 0;
        prev_valid = 1'b0;
        chk_all("async_reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("reset_held", 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive('{0, 0, 2'b00, 3'b000, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0});
        tick();
        chk_all("after_reset", 0, 0, 0, 0, 0);

        drive('{1, 1, 2'b00, 3'b000, 5'd3, 32'h0000_0011, 0, 0, 0, 0, 0, 0, 0});
        for (int i = 0; i < 256; i++) tick();
        chk("wrap_pre8", 32'(n_cnt), 32'd255);
        chk("wrap_pre32", o_cnt, 32'd255);
        tick();
        chk("wrap8", 32'(n_cnt), 32'd0);
        chk("wrap32", o_cnt, 32'd256);
        chk("wrap8_data", 32'(n_data), 32'h11);
        chk("wrap8_rw", 32'(n_rw), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
MEM/WB pipeline stage of the RISC-V core and the write-side driver of the register bank's write port (REGWRITE, ADR_WR_REG, WR_DATA).
- Captures memory-stage results on the rising edge.
- Extracts and extends load data, selects the writeback source and presents a stable write request. The register bank samples that request on the following falling edge.
- Supports stall and flush, and keeps a retired-instruction counter.

Parameters:
WIDTH, 32, data/register width in bits
DEPTH, 32, number of architectural registers; AW = $clog2(DEPTH)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
MEM_VALID  in  1  memory stage holds a real instruction
MEM_REGWRITE  in  1  instruction writes rd
MEM_WB_SEL  in  2  writeback source: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM
MEM_FUNCT3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
MEM_ADR_WR_REG  in  AW  destination register rd
MEM_ALU_RESULT  in  WIDTH  ALU result / load address
MEM_RD_DATA  in  WIDTH  raw aligned word from data memory
MEM_PC_PLUS4  in  WIDTH  return address
MEM_IMM  in  WIDTH  immediate (LUI)
STALL  in  1  hold stage contents
FLUSH  in  1  replace stage contents with a bubble
REGWRITE  out  1  register bank write enable
ADR_WR_REG  out  AW  register bank write address
WR_DATA  out  WIDTH  register bank write data
WB_VALID  out  1  stage holds a valid instruction
LOAD_ERR  out  1  valid load with an illegal funct3
RETIRE_COUNT  out  WIDTH  instructions retired since reset

Behaviour:
- Reset (rst=0, asynchronous): all stage registers clear. REGWRITE=0, ADR_WR_REG=0, WR_DATA=0, WB_VALID=0, LOAD_ERR=0, RETIRE_COUNT=0. Reset mid-stall or mid-flush discards the held instruction.
- Capture on posedge clk, with priority FLUSH > STALL > load:
  - FLUSH=1: valid register <= 0, all other stage fields <= 0. This applies even if STALL=1.
  - STALL=1, FLUSH=0: all stage registers hold.
  - Otherwise: all MEM_* fields are registered.
- Latency: one cycle. Inputs at edge n appear on the outputs after edge n and remain stable through the falling edge of cycle n, where the register bank writes.
- REGWRITE = valid & regwrite & (rd != 0) & !LOAD_ERR. It is never asserted for x0.
- ADR_WR_REG = registered rd, driven regardless of REGWRITE.
- WR_DATA is a combinational mux of the registered fields per WB_SEL. It is forced to 0 when valid=0.
- Load extraction uses offset = registered ALU_RESULT[1:0]:
  - LB/LBU: byte = RD_DATA[8*offset +: 8], then sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: half = RD_DATA[16*offset[1] +: 16], then sign-extended (LH) or zero-extended (LHU). offset[0] is ignored; alignment checking belongs to the memory stage.
  - LW: full word, offset ignored.
  - funct3 in {011, 110, 111} with WB_SEL=LOAD and valid: LOAD_ERR=1, WR_DATA = raw word, REGWRITE=0.
- RETIRE_COUNT increments by 1 on each posedge where WB_VALID=1 and the stage is not stalled. It wraps from 2^WIDTH-1 to 0.
  - A stalled instruction is counted once, on the edge where it leaves the stage. A flushed instruction is counted if it was valid before the flush edge.
- A repeated STALL never re-asserts a write with different data. Outputs are constant while stalled, so re-writing the same value to the same register is harmless.

Decomposition:
- Package rv_wb_pkg:
  - wb_sel_t enum (WB_ALU, WB_LOAD, WB_PC4, WB_IMM).
  - Load funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
- Sub-module load_extend: purely combinational. Inputs raw word, offset, funct3. Outputs extended data and illegal flag. Parameterised by WIDTH.
- The stage registers, the mux and the retire counter stay in mem_wb_writeback.

Test Plan:
- Reset: drive rst=0 mid-cycle with a valid ALU write pending -> all outputs 0 immediately (asynchronous); after release, RETIRE_COUNT=0.
- ALU write: VALID=1, REGWRITE=1, WB_SEL=00, rd=5, ALU_RESULT=0x0000_1234 -> next cycle REGWRITE=1, ADR_WR_REG=5, WR_DATA=0x1234; RETIRE_COUNT=1 after the following edge. Same request with rd=0 -> REGWRITE=0.
- Loads with RD_DATA=0x8070_60F0:
  - LB, ALU_RESULT=0x1003 -> WR_DATA=0xFFFF_FF80.
  - LBU, offset 0 -> 0x0000_00F0.
  - LH, offset 2 -> 0xFFFF_8070.
  - LHU, offset 2 -> 0x0000_8070.
  - LW -> 0x8070_60F0.
- Illegal load: funct3=011 -> LOAD_ERR=1, REGWRITE=0, WR_DATA=0x8070_60F0.
- Stall/flush:
  - Load PC+4 instruction (PC_PLUS4=0x100, rd=1), then STALL=1 for 3 cycles while inputs change -> outputs hold at 0x100/rd=1; RETIRE_COUNT increments once, when the stall releases.
  - FLUSH=1 with STALL=1 -> WB_VALID=0, REGWRITE=0, WR_DATA=0.
- Counter wrap: run with WIDTH=8 and 256 valid instructions -> RETIRE_COUNT returns to 0.
